// File: rtl/cpu_exec_datapath.sv
// cpu_exec_datapath: 16-bit register file, ALU, PC and IR stepped by the control word
module cpu_exec_datapath #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] REG_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  W_Adr,
  input  logic [2:0]  R_Adr,
  input  logic [2:0]  S_Adr,
  input  logic        adr_sel,
  input  logic        s_sel,
  input  logic        pc_ld,
  input  logic        pc_inc,
  input  logic        pc_sel,
  input  logic        ir_ld,
  input  logic        rw_en,
  input  logic [3:0]  alu_op,
  input  logic [15:0] mem_din,
  output logic [15:0] Address,
  output logic [15:0] D_out,
  output logic [15:0] IR,
  output logic        N,
  output logic        Z,
  output logic        C
);
  logic [15:0] rf_q [8];
  logic [15:0] pc_q, pc_d, ir_q, ir_d, r, s, sm, alu_out;
  logic [16:0] alu17;
  assign r = rf_q[R_Adr];
  assign s = rf_q[S_Adr];
  assign sm = s_sel ? mem_din : s;
  always_comb begin
    alu17 = {1'b0, sm};
    case (alu_op)
      4'd0: alu17 = {1'b0, r} + {1'b0, sm};
      4'd1, 4'd2: alu17 = {1'b0, r} - {1'b0, sm};
      4'd4: alu17 = {sm, 1'b0};
      4'd5: alu17 = {2'b00, sm[15:1]};
      4'd6: alu17 = {1'b0, sm} + 17'd1;
      4'd7: alu17 = {1'b0, sm} - 17'd1;
      default: alu17 = {1'b0, sm};
    endcase
  end
  assign alu_out = alu17[15:0];
  assign C = (alu_op == 4'd5) ? sm[0] :
             (alu_op == 4'd3 || alu_op[3]) ? 1'b0 : alu17[16];
  assign N = alu_out[15];
  assign Z = (alu_out == 16'h0000);
  assign Address = adr_sel ? r : pc_q;
  assign D_out = s;
  assign IR = ir_q;
  assign pc_d = pc_ld ? (pc_sel ? alu_out : pc_q + {{8{ir_q[7]}}, ir_q[7:0]}) :
                pc_inc ? pc_q + 16'd1 : pc_q;
  assign ir_d = ir_ld ? mem_din : ir_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      ir_q <= 16'h0000;
      for (int i = 0; i < 8; i++) rf_q[i] <= REG_RESET;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      if (rw_en) rf_q[W_Adr] <= alu_out;
    end
  end
endmodule

// File: doc/cpu_exec_datapath.md
Name: cpu_exec_datapath

Overview:
- 16-bit execution unit driven cycle-by-cycle by the CPU control unit's control word.
- Holds the 8x16 register file, ALU, PC and IR.
- Presents the memory address and write data, and returns the N/Z/C status and IR to the control unit.
- Memory, including the mw_en write strobe, is external. mem_din is the asynchronous read data for the current Address.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- REG_RESET, 16'h0000, value of every register-file entry after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- W_Adr  in  3  register-file write address.
- R_Adr  in  3  register-file R read address.
- S_Adr  in  3  register-file S read address.
- adr_sel  in  1  Address mux: 0 = PC, 1 = R operand.
- s_sel  in  1  ALU S-input mux: 0 = S operand, 1 = mem_din.
- pc_ld  in  1  load PC.
- pc_inc  in  1  increment PC.
- pc_sel  in  1  PC load source: 0 = PC + sext(IR[7:0]), 1 = ALU_Out.
- ir_ld  in  1  load IR from mem_din.
- rw_en  in  1  register-file write enable.
- alu_op  in  4  ALU operation.
- mem_din  in  16  memory read data.
- Address  out  16  memory address.
- D_out  out  16  memory write data (S operand).
- IR  out  16  instruction register.
- N  out  1  ALU result[15], combinational.
- Z  out  1  ALU result == 0, combinational.
- C  out  1  ALU carry/borrow/shift-out, combinational.

Behaviour:
- Reset (reset = 0, asynchronous): PC = RESET_PC, IR = 0, all eight registers = REG_RESET. Outputs follow combinationally from these values.
- Register file:
  - Two asynchronous read ports, R = reg[R_Adr] and S = reg[S_Adr].
  - One synchronous write port: reg[W_Adr] <= ALU_Out at posedge when rw_en = 1.
  - Read of the address being written returns the old value in that cycle; the new value is visible the cycle after the edge.
  - Register 0 is an ordinary writable register.
- S mux: Sm = s_sel ? mem_din : S.
- ALU is combinational and uses 17-bit internal arithmetic. C is bit 16 unless stated.
  - 0 ADD: R + Sm.
  - 1 SUB: R - Sm. C = borrow (1 when R < Sm, unsigned).
  - 2 CMP: same as SUB. The result is not written because the control unit deasserts rw_en.
  - 3 MOV: Sm, C = 0.
  - 4 SHL: Sm << 1, C = Sm[15].
  - 5 SHR: logical Sm >> 1, C = Sm[0].
  - 6 INC: Sm + 1. C = 1 only when Sm = FFFF.
  - 7 DEC: Sm - 1. C = 1 only when Sm = 0000.
  - 8 through F: pass Sm, C = 0.
  - Wrap-around is modulo 2^16 in all cases.
- Flags: N = ALU_Out[15] and Z = (ALU_Out == 0) for every op. N/Z/C are not registered here; the control unit captures them.
- Address = adr_sel ? R : PC.
- D_out = S. It is the raw register value and never uses mem_din.
- PC update at posedge, priority pc_ld over pc_inc:
  - pc_ld = 1: PC <= pc_sel ? ALU_Out : PC + {{8{IR[7]}}, IR[7:0]}.
  - pc_ld = 0, pc_inc = 1: PC <= PC + 1, with FFFF wrapping to 0000.
  - Otherwise PC holds.
- IR: IR <= mem_din at posedge when ir_ld = 1, else holds. The relative-branch target uses the IR value before any same-edge IR load.
- Same-edge events: ir_ld, pc_inc and rw_en may all be asserted in one cycle. Each register samples its pre-edge inputs, e.g. LDI writes mem_din fetched at the old PC while PC increments.
- Reset mid-operation: all state returns to reset values immediately and no write lands. On reset release the first posedge acts normally.
- Latency: ALU/flag/Address outputs respond combinationally to control inputs. Register/PC/IR effects appear one edge later.

Test Plan:
- Reset: assert reset low mid-cycle after nonzero writes -> PC = 0000, IR = 0000, reg[0..7] = 0000 immediately; Address = 0000.
- Fetch: mem_din = 7000 at Address 0000, ir_ld = pc_inc = 1 for one edge -> IR = 7000, PC = 0001; a second edge with only pc_inc gives PC = 0002.
- Arithmetic:
  - Load r1 = FFFF and r2 = 0001 via s_sel = 1/MOV.
  - ADD into r3 -> r3 = 0000, Z = 1, C = 1, N = 0.
  - SUB r2 - r1 -> 0002, C = 1.
  - SHR of 0001 -> 0000, C = 1, Z = 1.
  - DEC of 0000 -> FFFF, N = 1, C = 1.
- Relative branch: PC = 0010, IR = 7CFE, pc_ld = 1, pc_sel = 0 -> PC = 000E. With IR = 7C05 -> PC = 0015. pc_ld + pc_inc together -> load wins.
- Store/load path: r4 = 0100, r5 = BEEF, adr_sel = 1, R_Adr = 4, S_Adr = 5 -> Address = 0100, D_out = BEEF. s_sel = 1, mem_din = 1234, W_Adr = 6, alu_op = 8, rw_en = 1 -> r6 = 1234 after the edge.
- Write/read hazard: W_Adr = R_Adr = 2, rw_en = 1, r2 old = 0005, ALU_Out = 0009 -> R reads 0005 before the edge and 0009 after. PC at FFFF with pc_inc -> 0000.
